pulse_period_meter: RTL and testbench

- Receive-side counterpart of the team's clock divider: measures the period of an external, asynchronous pulse or clock input in `clk` cycles.
- Sits in the TinyTapeout top between a `ui_in` pin and the readout logic; the divider output can be looped back into it for self-test.
- Synchronizes the input, detects rising edges, counts `clk` cycles between successive edges, and publishes each completed period with a one-cycle valid strobe.
- Flags counter saturation (input too slow or stuck).

---
 rtl/pulse_meter_pkg.sv | 17 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/pulse_period_meter.sv | 144 ++++++++++++++
 tb/tb_pulse_period_meter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse period meter and its edge detector.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StOverflow
  } state_e;

  localparam int unsigned AvgDepth = 4;

  // All-ones value of a counter of the given width.
  function automatic int unsigned cnt_max(int unsigned width);
    return (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input with a one-cycle rising-edge pulse.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_sync,
  output logic sig_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_sync = sync_q[SYNC_STAGES-1];
  assign sig_rise = sig_sync & ~hist_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the period of an asynchronous input in clk cycles between rising edges.
// Define PULSE_PERIOD_AVG_EN to report a 4-period running average instead of raw periods.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic sig_sync;
  logic sig_rise;
  logic rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .sig_sync(sig_sync),
    .sig_rise(sig_rise)
  );

  // A rise always implies the synchronized level is high; qualifying keeps both outputs in use.
  assign rise = sig_rise & sig_sync;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] raw_period_q;
  logic             raw_valid_q;
  logic             overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      raw_period_q <= '0;
      raw_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      raw_valid_q <= 1'b0;
      if (!ena) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        overflow_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              cnt_q   <= CntOne;
              state_q <= StMeasure;
            end
          end
          StMeasure: begin
            // An edge on the saturating cycle still reports CntMax as a valid period.
            if (rise) begin
              raw_period_q <= cnt_q;
              raw_valid_q  <= 1'b1;
              overflow_q   <= 1'b0;
              cnt_q        <= CntOne;
            end else if (cnt_q == CntMax) begin
              overflow_q <= 1'b1;
              state_q    <= StOverflow;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StOverflow: begin
            if (rise) begin
              cnt_q   <= CntOne;
              state_q <= StMeasure;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign overflow = overflow_q;
  assign busy     = (state_q == StMeasure);

`ifdef PULSE_PERIOD_AVG_EN
  localparam int unsigned SumW = CNT_W + 2;

  logic [CNT_W-1:0] hist_q [AvgDepth];
  logic [SumW-1:0]  sum_q;
  logic [SumW-1:0]  sum_d;
  logic [2:0]       fill_q;
  logic [CNT_W-1:0] avg_q;
  logic             avg_valid_q;

  always_comb begin
    sum_d = sum_q + SumW'(raw_period_q) - SumW'(hist_q[AvgDepth-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AvgDepth; i++) hist_q[i] <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else if (!ena || state_q != StMeasure) begin
      // History restarts on every exit from idle or overflow; the last average is kept.
      for (int i = 0; i < AvgDepth; i++) hist_q[i] <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (raw_valid_q) begin
        hist_q[0] <= raw_period_q;
        for (int i = 1; i < AvgDepth; i++) hist_q[i] <= hist_q[i-1];
        sum_q <= sum_d;
        if (fill_q != 3'(AvgDepth)) fill_q <= fill_q + 3'd1;
        if (fill_q >= 3'(AvgDepth - 1)) begin
          avg_q       <= sum_d[SumW-1:2];
          avg_valid_q <= 1'b1;
        end
      end
    end
  end

  assign period       = avg_q;
  assign period_valid = avg_valid_q;
`else
  assign period       = raw_period_q;
  assign period_valid = raw_valid_q;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: vector table plus hand-written corner sequences.
module tb_pulse_period_meter;

  localparam int unsigned CNT_W = 8;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             ena    = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             overflow;
  logic             busy;

  pulse_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .sig_in      (sig_in),
    .period      (period),
    .period_valid(period_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  typedef struct {
    int hi;
    int lo;
    int edges;
    int exp_period;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Square wave; every rising edge except one leaving idle is expected to report exp_period.
  task automatic square(input int hi, input int lo, input int edges, input bit from_idle,
                        input int exp_period);
    for (int i = 0; i < edges; i++) begin
      sig_in = 1'b1;
      if (!(from_idle && i == 0)) exp_q.push_back(exp_period);
      tick(hi);
      sig_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic pulse_gap(input int gap);
    sig_in = 1'b1;
    tick(1);
    sig_in = 1'b0;
    tick(gap - 1);
  endtask

  task automatic drain(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic go_idle();
    ena    = 1'b0;
    sig_in = 1'b0;
    tick(4);
    ena = 1'b1;
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && period_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got period %0d, expected no strobe", period);
      end else begin
        check("period", int'(period), exp_q.pop_front());
        check("overflow_at_strobe", int'(overflow), 0);
      end
    end
  end

`ifndef PULSE_PERIOD_AVG_EN
  vec_t vecs[7];
`endif

  initial begin
    tick(3);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(period_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(2);
    ena = 1'b1;

`ifndef PULSE_PERIOD_AVG_EN
    vecs[0] = '{hi: 5,   lo: 5,   edges: 4, exp_period: 10};
    vecs[1] = '{hi: 1,   lo: 1,   edges: 6, exp_period: 2};
    vecs[2] = '{hi: 3,   lo: 4,   edges: 4, exp_period: 7};
    vecs[3] = '{hi: 2,   lo: 1,   edges: 4, exp_period: 3};
    vecs[4] = '{hi: 6,   lo: 6,   edges: 3, exp_period: 12};
    vecs[5] = '{hi: 120, lo: 134, edges: 3, exp_period: 254};
    vecs[6] = '{hi: 128, lo: 127, edges: 3, exp_period: 255};

    foreach (vecs[v]) begin
      go_idle();
      square(vecs[v].hi, vecs[v].lo, vecs[v].edges, 1'b1, vecs[v].exp_period);
      tick(6);
      drain("vec_drain");
    end

    // Input stuck low long enough to saturate the 8-bit counter.
    go_idle();
    pulse_gap(300);
    check("ovf_set", int'(overflow), 1);
    check("ovf_busy", int'(busy), 0);
    sig_in = 1'b1;
    tick(10);
    check("ovf_exit_sticky", int'(overflow), 1);
    check("ovf_exit_busy", int'(busy), 1);
    sig_in = 1'b0;
    tick(10);
    square(10, 10, 1, 1'b0, 20);
    tick(6);
    check("ovf_cleared", int'(overflow), 0);
    drain("ovf_drain");

    // Enable dropped mid-count while a 12-cycle signal keeps running.
    go_idle();
    square(6, 6, 4, 1'b1, 12);
    sig_in = 1'b1;
    exp_q.push_back(12);
    tick(6);
    sig_in = 1'b0;
    tick(2);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("ena_low_period", int'(period), 12);
      check("ena_low_busy", int'(busy), 0);
    end
    ena = 1'b1;
    tick(4);
    square(6, 6, 2, 1'b1, 12);
    tick(6);
    drain("ena_drain");

    // Asynchronous reset between clock edges, then a cold start.
    go_idle();
    square(5, 5, 3, 1'b1, 10);
    tick(4);
    check("pre_rst_period", int'(period), 10);
    sig_in = 1'b1;
    tick(2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_period", int'(period), 0);
    check("arst_valid", int'(period_valid), 0);
    check("arst_overflow", int'(overflow), 0);
    check("arst_busy", int'(busy), 0);
    sig_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_busy", int'(busy), 0);
    square(5, 5, 3, 1'b1, 10);
    tick(6);
    drain("rst_drain");
`else
    // Averaging: raw 8,8,12,12 give the first strobe; a following 16 slides the window.
    go_idle();
    pulse_gap(8);
    pulse_gap(8);
    pulse_gap(12);
    pulse_gap(12);
    exp_q.push_back(10);
    pulse_gap(16);
    exp_q.push_back(12);
    pulse_gap(10);
    tick(4);
    drain("avg_drain");
`endif

    tick(5);
    drain("final_drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
